// File: rtl/dmem_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_host_ctrl
// Description : Host-side sequencer around a multi-core data memory.
//               On cmd_go it streams load_count words into memory, pulses
//               the core reset, starts the cores, counts run cycles until
//               END, then streams dump_start..dump_end-1 back out.
// Ports       : clk, RESET          - clock, synchronous active-high reset
//               cmd_go, load_count,
//               dump_start, dump_end - command and its parameters
//               in_*                 - load stream (valid/ready)
//               addr_mux_select, current_addr, mem_data, write_from_tb
//                                    - memory load path to the top
//               core_rst, START, END - core control / completion
//               ar_in, dmem_out_disp - readback address / data
//               out_*                - dump stream (valid/ready)
//               busy, done, run_cycles - status
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_host_ctrl #(
    parameter int DW     = 16,
    parameter int AW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          cmd_go,
    input  logic [AW-1:0] load_count,
    input  logic [AW-1:0] dump_start,
    input  logic [AW-1:0] dump_end,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [1:0]    addr_mux_select,
    output logic [AW-1:0] current_addr,
    output logic [DW-1:0] mem_data,
    output logic          write_from_tb,
    output logic          core_rst,
    output logic          START,
    input  logic          END,
    output logic [AW-1:0] ar_in,
    input  logic [DW-1:0] dmem_out_disp,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [31:0]   run_cycles
);

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_LOAD  = 4'd1;
    localparam logic [3:0] c_CRST  = 4'd2;
    localparam logic [3:0] c_KICK  = 4'd3;
    localparam logic [3:0] c_RUN   = 4'd4;
    localparam logic [3:0] c_DADDR = 4'd5;
    localparam logic [3:0] c_DWAIT = 4'd6;
    localparam logic [3:0] c_DOUT  = 4'd7;
    localparam logic [3:0] c_DONE  = 4'd8;

    // DWAIT always lasts at least one cycle so a zero latency still works.
    localparam int          c_LAT      = (RD_LAT < 1) ? 1 : RD_LAT;
    localparam logic [15:0] c_LAT_LAST = 16'(c_LAT - 1);

    logic [3:0]    r_state;
    logic [AW-1:0] r_load_cnt;
    logic [AW-1:0] r_load_addr;
    logic [AW-1:0] r_dump_start;
    logic [AW-1:0] r_dump_end;
    logic [AW-1:0] r_dump_addr;
    logic          r_crst_cnt;
    logic [15:0]   r_lat_cnt;

    logic [AW-1:0] w_load_addr_nxt;
    logic [AW-1:0] w_dump_addr_nxt;
    logic          w_run_sat;

    assign w_load_addr_nxt = r_load_addr + 1'b1;
    assign w_dump_addr_nxt = r_dump_addr + 1'b1;
    assign w_run_sat       = &run_cycles;

    // All outputs are registered and updated together with the state, so
    // each branch sets the outputs that belong to the state being entered.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state         <= c_IDLE;
            r_load_cnt      <= '0;
            r_load_addr     <= '0;
            r_dump_start    <= '0;
            r_dump_end      <= '0;
            r_dump_addr     <= '0;
            r_crst_cnt      <= 1'b0;
            r_lat_cnt       <= '0;
            in_ready        <= 1'b0;
            addr_mux_select <= 2'd0;
            current_addr    <= '0;
            mem_data        <= '0;
            write_from_tb   <= 1'b0;
            core_rst        <= 1'b0;
            START           <= 1'b0;
            ar_in           <= '0;
            out_data        <= '0;
            out_valid       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            run_cycles      <= '0;
        end else begin
            if ((r_state == c_KICK || r_state == c_RUN) && !w_run_sat) begin
                run_cycles <= run_cycles + 32'd1;
            end

            case (r_state)
                c_IDLE, c_DONE: begin
                    if (cmd_go) begin
                        r_load_cnt   <= load_count;
                        r_dump_start <= dump_start;
                        r_dump_end   <= dump_end;
                        r_dump_addr  <= dump_start;
                        r_load_addr  <= '0;
                        run_cycles   <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        if (load_count == '0) begin
                            r_state    <= c_CRST;
                            r_crst_cnt <= 1'b0;
                            core_rst   <= 1'b1;
                        end else begin
                            r_state         <= c_LOAD;
                            addr_mux_select <= 2'd1;
                            in_ready        <= 1'b1;
                        end
                    end
                end

                c_LOAD: begin
                    if (write_from_tb) begin
                        // Write cycle ends; r_load_addr already counts it.
                        write_from_tb <= 1'b0;
                        if (r_load_addr == r_load_cnt) begin
                            r_state         <= c_CRST;
                            r_crst_cnt      <= 1'b0;
                            core_rst        <= 1'b1;
                            addr_mux_select <= 2'd0;
                        end else begin
                            in_ready <= 1'b1;
                        end
                    end else if (in_valid && in_ready) begin
                        mem_data      <= in_data;
                        current_addr  <= r_load_addr;
                        write_from_tb <= 1'b1;
                        in_ready      <= 1'b0;
                        r_load_addr   <= w_load_addr_nxt;
                    end
                end

                c_CRST: begin
                    if (!r_crst_cnt) begin
                        r_crst_cnt <= 1'b1;
                    end else begin
                        core_rst <= 1'b0;
                        START    <= 1'b1;
                        r_state  <= c_KICK;
                    end
                end

                // END is deliberately not looked at here.
                c_KICK: begin
                    START   <= 1'b0;
                    r_state <= c_RUN;
                end

                c_RUN: begin
                    if (END) begin
                        if (r_dump_start >= r_dump_end) begin
                            r_state <= c_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state         <= c_DADDR;
                            addr_mux_select <= 2'd2;
                            ar_in           <= r_dump_addr;
                        end
                    end
                end

                c_DADDR: begin
                    r_state   <= c_DWAIT;
                    r_lat_cnt <= '0;
                end

                c_DWAIT: begin
                    if (r_lat_cnt == c_LAT_LAST) begin
                        out_data  <= dmem_out_disp;
                        out_valid <= 1'b1;
                        r_state   <= c_DOUT;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 16'd1;
                    end
                end

                c_DOUT: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        r_dump_addr <= w_dump_addr_nxt;
                        if (w_dump_addr_nxt == r_dump_end) begin
                            r_state         <= c_DONE;
                            busy            <= 1'b0;
                            done            <= 1'b1;
                            addr_mux_select <= 2'd0;
                        end else begin
                            r_state <= c_DADDR;
                            ar_in   <= w_dump_addr_nxt;
                        end
                    end
                end

                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
